counter_overflow_monitor: RTL and testbench

Downstream consumer of the 4-bit enabled up-counter and its sticky overflow flag. It samples the counter value and detects every 4'hF -> 4'h0 wrap. It accumulates wraps in a saturating extension counter and exposes a combined wide count. When a programmable wrap threshold is reached, it raises an interrupt request under a four-phase req/ack handshake.

---
 rtl/counter_overflow_monitor.sv | 106 ++++++++++
 tb/tb_counter_overflow_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/counter_overflow_monitor.sv
// Watches a free-running 4-bit counter for F->0 wraps and extends it with a saturating wrap count.
// It raises a four-phase req/ack interrupt when a programmable number of wraps has built up.
module counter_overflow_monitor #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cnt_in,
  input  logic              ovf_in,
  input  logic [WRAP_W-1:0] thr_in,
  input  logic              clr_in,
  input  logic              irq_ack,
  output logic              irq_out,
  output logic [WRAP_W-1:0] wrap_cnt_out,
  output logic [WRAP_W+3:0] ext_cnt_out,
  output logic              ovf_seen_out
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;

  logic [3:0]        cnt_reg;
  logic              ovf_reg;
  logic              primed_reg;
  logic [1:0]        state_reg, state_next;
  logic [WRAP_W-1:0] wrap_reg, wrap_next;
  logic              ovf_seen_reg, ovf_seen_next;
  logic              irq_reg;
  logic              wrap_ev;
  logic              ack_in_req;

  // primed blocks a false wrap from the reset value of cnt_reg
  assign wrap_ev    = primed_reg && (cnt_reg == 4'hF) && (cnt_in == 4'h0);
  assign ack_in_req = (state_reg == REQ) && irq_ack;

  always_comb begin
    wrap_next = wrap_reg;
    if (clr_in) begin
      wrap_next = '0;
    end else if (ack_in_req) begin
      wrap_next = wrap_ev ? WRAP_W'(1) : '0;
    end else if (wrap_ev && !(&wrap_reg)) begin
      wrap_next = wrap_reg + WRAP_W'(1);
    end
  end

  always_comb begin
    ovf_seen_next = ovf_seen_reg;
    if (ovf_in && !ovf_reg) begin
      ovf_seen_next = 1'b1;
    end else if (clr_in) begin
      ovf_seen_next = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if ((thr_in != '0) && (wrap_reg >= thr_in) && !clr_in) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (clr_in) begin
          state_next = IDLE;
        end else if (irq_ack) begin
          state_next = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!irq_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg      <= 4'h0;
      ovf_reg      <= 1'b0;
      primed_reg   <= 1'b0;
      state_reg    <= IDLE;
      wrap_reg     <= '0;
      ovf_seen_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      cnt_reg      <= cnt_in;
      ovf_reg      <= ovf_in;
      primed_reg   <= 1'b1;
      state_reg    <= state_next;
      wrap_reg     <= wrap_next;
      ovf_seen_reg <= ovf_seen_next;
      irq_reg      <= (state_next == REQ);
    end
  end

  assign irq_out      = irq_reg;
  assign wrap_cnt_out = wrap_reg;
  assign ext_cnt_out  = {wrap_reg, cnt_reg};
  assign ovf_seen_out = ovf_seen_reg;

endmodule

// File: tb/tb_counter_overflow_monitor.sv
// Directed plus randomized bench; two instances (WRAP_W=8 and WRAP_W=2) share stimulus
// and are compared each cycle against a behavioural model of wraps and the handshake.
module tb_counter_overflow_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cnt_in;
  logic       ovf_in;
  logic       clr_in;
  logic       irq_ack;
  logic [7:0] thr_in;
  logic [1:0] thr2;

  logic        irq8, seen8, irq2, seen2;
  logic [7:0]  wrap8;
  logic [11:0] ext8;
  logic [1:0]  wrap2;
  logic [5:0]  ext2;

  int checks = 0;
  int errors = 0;

  // model state
  bit         m_primed;
  logic [3:0] m_cnt_q;
  bit         m_ovf_q;
  bit         m_seen;
  int         m_w8;
  int         m_w2;
  bit         m_irq;
  bit         m_wait;

  always #5 clk = ~clk;

  counter_overflow_monitor #(.WRAP_W(8)) dut8 (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .ovf_in(ovf_in), .thr_in(thr_in),
    .clr_in(clr_in), .irq_ack(irq_ack), .irq_out(irq8), .wrap_cnt_out(wrap8),
    .ext_cnt_out(ext8), .ovf_seen_out(seen8)
  );

  counter_overflow_monitor #(.WRAP_W(2)) dut2 (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .ovf_in(ovf_in), .thr_in(thr2),
    .clr_in(clr_in), .irq_ack(irq_ack), .irq_out(irq2), .wrap_cnt_out(wrap2),
    .ext_cnt_out(ext2), .ovf_seen_out(seen2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit wrap, fire;
    if (reset) begin
      m_primed = 0; m_cnt_q = 4'h0; m_ovf_q = 0; m_seen = 0;
      m_w8 = 0; m_w2 = 0; m_irq = 0; m_wait = 0;
      return;
    end
    wrap = m_primed && (m_cnt_q == 4'hF) && (cnt_in == 4'h0);
    fire = !m_irq && !m_wait && (thr_in != 0) && (m_w8 >= int'(thr_in)) && !clr_in;
    if (clr_in) m_w8 = 0;
    else if (m_irq && irq_ack) m_w8 = wrap ? 1 : 0;
    else if (wrap && m_w8 < 255) m_w8++;
    if (clr_in) m_w2 = 0;
    else if (wrap && m_w2 < 3) m_w2++;
    if (m_irq) begin
      if (clr_in) m_irq = 0;
      else if (irq_ack) begin m_irq = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (!irq_ack) m_wait = 0;
    end else if (fire) begin
      m_irq = 1;
    end
    if (ovf_in && !m_ovf_q) m_seen = 1;
    else if (clr_in) m_seen = 0;
    m_cnt_q  = cnt_in;
    m_ovf_q  = ovf_in;
    m_primed = 1;
  endtask

  task automatic tick();
    logic [7:0] ew8;
    logic [1:0] ew2;
    model_edge();
    @(posedge clk);
    #1;
    ew8 = m_w8[7:0];
    ew2 = m_w2[1:0];
    chk("irq8",  {31'd0, irq8},  {31'd0, m_irq});
    chk("wrap8", {24'd0, wrap8}, {24'd0, ew8});
    chk("ext8",  {20'd0, ext8},  {20'd0, ew8, m_cnt_q});
    chk("seen8", {31'd0, seen8}, {31'd0, m_seen});
    chk("irq2",  {31'd0, irq2},  32'd0);
    chk("wrap2", {30'd0, wrap2}, {30'd0, ew2});
    chk("ext2",  {26'd0, ext2},  {26'd0, ew2, m_cnt_q});
    chk("seen2", {31'd0, seen2}, {31'd0, m_seen});
  endtask

  task automatic drv(input logic [3:0] c, input bit o, input bit k, input bit a);
    cnt_in = c; ovf_in = o; clr_in = k; irq_ack = a;
    tick();
  endtask

  initial begin
    int ack_left;
    reset = 1'b1; cnt_in = 4'h0; ovf_in = 1'b0; clr_in = 1'b0; irq_ack = 1'b0;
    thr_in = 8'd0; thr2 = 2'd0;
    tick();
    tick();
    reset = 1'b0;

    // free-running count, threshold disabled: six wraps saturate the 2-bit instance
    for (int i = 0; i < 6 * 16 + 1; i++) begin
      drv(4'(i), 1'b0, 1'b0, 1'b0);
      if (i == 16) begin
        chk("first_wrap8", {24'd0, wrap8}, 32'd1);
        chk("first_ext8", {20'd0, ext8}, 32'h010);
      end
    end
    chk("sat2", {30'd0, wrap2}, 32'd3);
    chk("no_irq_thr0", {31'd0, irq8}, 32'd0);

    // threshold 3 with a two-cycle ack pulse whenever the request is up
    drv(4'h1, 1'b0, 1'b1, 1'b0);
    thr_in = 8'd3;
    ack_left = 0;
    for (int i = 0; i < 120; i++) begin
      if (m_irq && ack_left == 0) ack_left = 2;
      drv(4'(i + 2), 1'b0, 1'b0, ack_left > 0);
      if (ack_left > 0) ack_left--;
    end

    // ack coincident with a wrap while in REQ
    drv(4'h3, 1'b0, 1'b1, 1'b0);
    thr_in = 8'd1;
    drv(4'hF, 1'b0, 1'b0, 1'b0);
    drv(4'h0, 1'b0, 1'b0, 1'b0);
    drv(4'h0, 1'b0, 1'b0, 1'b0);
    chk("irq_up", {31'd0, irq8}, 32'd1);
    drv(4'hF, 1'b0, 1'b0, 1'b0);
    drv(4'h0, 1'b0, 1'b0, 1'b1);
    chk("ack_wrap_cnt", {24'd0, wrap8}, 32'd1);
    drv(4'h1, 1'b0, 1'b0, 1'b1);
    drv(4'h2, 1'b0, 1'b0, 1'b0);
    drv(4'h3, 1'b0, 1'b0, 1'b0);

    // clear while requesting
    drv(4'h4, 1'b0, 1'b1, 1'b0);
    drv(4'hF, 1'b0, 1'b0, 1'b0);
    drv(4'h0, 1'b0, 1'b0, 1'b0);
    drv(4'h1, 1'b0, 1'b0, 1'b0);
    drv(4'h2, 1'b0, 1'b1, 1'b0);
    chk("clr_in_req", {31'd0, irq8}, 32'd0);
    drv(4'h3, 1'b0, 1'b0, 1'b1);
    drv(4'h4, 1'b0, 1'b0, 1'b0);

    // overflow rise during clear, then clear alone
    thr_in = 8'd0;
    drv(4'h5, 1'b1, 1'b1, 1'b0);
    chk("ovf_set_wins", {31'd0, seen8}, 32'd1);
    drv(4'h6, 1'b1, 1'b1, 1'b0);
    chk("ovf_cleared", {31'd0, seen8}, 32'd0);
    drv(4'h7, 1'b0, 1'b0, 1'b0);

    // only a genuine F->0 step counts
    drv(4'hF, 1'b0, 1'b0, 1'b0);
    drv(4'hF, 1'b0, 1'b0, 1'b0);
    drv(4'h0, 1'b0, 1'b0, 1'b0);
    drv(4'h7, 1'b0, 1'b0, 1'b0);
    drv(4'h0, 1'b0, 1'b0, 1'b0);
    chk("one_wrap", {24'd0, wrap8}, 32'd1);

    // randomized traffic including mid-handshake resets
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70)      cnt_in = cnt_in + 4'd1;
      else if (r < 80) cnt_in = cnt_in;
      else if (r < 90) cnt_in = 4'h0;
      else             cnt_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) ovf_in = ~ovf_in;
      clr_in  = ($urandom_range(0, 49) == 0);
      irq_ack = ($urandom_range(0, 2) == 0);
      reset   = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) thr_in = 8'($urandom_range(0, 4));
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
